// File: rtl/display_pkg.sv
// Shared constants, conversion FSM states and the double-dabble nibble adjust
// used by display_scan_ctrl and bin2bcd_seq.
package display_pkg;

    localparam logic [1:0] DIG_HUNDREDS = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_ONES     = 2'd2;
    localparam logic [1:0] DIG_LAST     = DIG_ONES;
    localparam logic [9:0] BCD_MAX      = 10'd999;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one add-3/shift step per clock for VAL_W
// clocks, then one COMMIT cycle with done=1 while bcd holds the result.
import display_pkg::*;

module bin2bcd_seq #(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd
);
    localparam int SW = 12 + VAL_W;
    localparam int CW = $clog2(VAL_W + 1);

    conv_state_e   state_q;
    logic [SW-1:0] scr_q;
    logic [SW-1:0] scr_adj;
    logic [SW-1:0] scr_shl;
    logic [CW-1:0] bit_cnt_q;
    logic          busy_q;
    logic          done_q;

    always_comb begin
        scr_adj = {dd_adj(scr_q[SW-1 -: 4]), dd_adj(scr_q[SW-5 -: 4]),
                   dd_adj(scr_q[SW-9 -: 4]), scr_q[VAL_W-1:0]};
        scr_shl = {scr_adj[SW-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scr_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        scr_q     <= {12'd0, bin};
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q     <= scr_shl;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(VAL_W - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = scr_q[SW-1 -: 12];

endmodule

// File: rtl/display_scan_ctrl.sv
// 3-digit scan controller: captures a saturated value, converts it to BCD and
// multiplexes the digits. Optional: LEADING_ZERO_BLANK_EN blanks leading zeros.
import display_pkg::*;

module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int VAL_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] val_in,
    input  logic             val_valid,
    output logic             val_ready,
    output logic [1:0]       dig_sel,
    output logic [3:0]       dig_bcd,
    output logic             dig_blank
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       sel_q, sel_d;
    logic [11:0]      disp_q, disp_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             blank_q, blank_d;
    logic             tick;
    logic             busy, done, start;
    logic [11:0]      conv_bcd;
    logic [VAL_W-1:0] val_sat;

    assign val_ready = ~busy;
    assign start     = val_valid & val_ready;
    assign val_sat   = (val_in > VAL_W'(BCD_MAX)) ? VAL_W'(BCD_MAX) : val_in;

    bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (val_sat),
        .busy  (busy),
        .done  (done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        tick    = (presc_q == CNT_W'(REFRESH_DIV - 1));
        presc_d = tick ? '0 : presc_q + CNT_W'(1);
        sel_d   = sel_q;
        if (tick) sel_d = (sel_q == DIG_LAST) ? DIG_HUNDREDS : sel_q + 2'd1;
        disp_d  = done ? conv_bcd : disp_q;
        // Digit and blank are derived from the next-state display so a commit
        // landing on a scan tick already shows the new value in the new slot.
        case (sel_d)
            DIG_HUNDREDS: bcd_d = disp_d[11:8];
            DIG_TENS:     bcd_d = disp_d[7:4];
            default:      bcd_d = disp_d[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank_d = ((sel_d == DIG_HUNDREDS) && (disp_d[11:8] == 4'd0)) ||
                  ((sel_d == DIG_TENS) && (disp_d[11:8] == 4'd0) && (disp_d[7:4] == 4'd0));
`else
        blank_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sel_q   <= DIG_HUNDREDS;
            disp_q  <= '0;
            bcd_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            disp_q  <= disp_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
        end
    end

    assign dig_sel   = sel_q;
    assign dig_bcd   = bcd_q;
    assign dig_blank = blank_q;

endmodule
